// File: rtl/regfile_wb.sv
// regfile_wb: write-back stage driving the register file write port.
// ALU results take strict priority; load results queue in a small FIFO
// and retire in order whenever the ALU slot is free. A busy mask tracks
// registers with outstanding loads for RAW-hazard stalls at issue.
module regfile_wb #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic [31:0] busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // FIFO storage and control
    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Write-port and busy-mask state
    logic          we3_q, we3_d;
    logic [4:0]    a3_q,  a3_d;
    logic [31:0]   wd3_q, wd3_d;
    logic [31:0]   busy_q, busy_d;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign ld_ready   = (count_q < FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = ld_valid && ld_ready;
    assign head_rd    = mem_rd[rd_ptr_q];
    assign head_data  = mem_data[rd_ptr_q];

    // Select the write-port source: ALU first, then FIFO head, else idle
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        pop   = 1'b0;
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (alu_valid) begin
            we3_d = (alu_rd != 5'd0);
            a3_d  = alu_rd;
            wd3_d = alu_data;
        end else if (!fifo_empty) begin
            pop   = 1'b1;
            we3_d = (head_rd != 5'd0);
            a3_d  = head_rd;
            wd3_d = head_data;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Busy mask: pop clears, issue sets afterwards so a same-cycle set wins
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (ld_issue_valid) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Register control state; reset discards queued loads and busy bits
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            busy_q   <= busy_d;
        end
    end

    // Write the accepted load result into the FIFO tail
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q guarantees stale entries are never read.
        if (push) begin
            mem_rd[wr_ptr_q]   <= ld_rd;
            mem_data[wr_ptr_q] <= ld_data;
        end
    end

    assign we3  = we3_q;
    assign a3   = a3_q;
    assign wd3  = wd3_q;
    assign busy = busy_q;

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-back unit that sits between the execute/memory stages and the register file. It is the sole driver of the register file write port (we3/a3/wd3).
- Merges two result sources:
  - single-cycle ALU results, with strict priority;
  - variable-latency load results, through a small FIFO with a valid/ready handshake.
- Keeps a busy mask of registers with outstanding loads so the issue stage can stall on RAW hazards.

Parameters:
- DEPTH, 2, number of load-result FIFO entries (≥1).
- CW, derived $clog2(DEPTH+1), width of the FIFO occupancy counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_issue_valid  in  1  a load was issued this cycle; marks ld_issue_rd busy.
- ld_issue_rd  in  5  destination register of the issued load.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  FIFO can accept a load result.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- we3  out  1  register file write enable (registered).
- a3  out  5  register file write address (registered).
- wd3  out  32  register file write data (registered).
- busy  out  32  per-register outstanding-load mask; bit 0 is constant 0.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously by design use):
  - we3=0, a3=0, wd3=0, busy=0.
  - FIFO empty with count=0, so ld_ready=1.
  - Reset mid-operation discards all FIFO contents and pending busy bits.
- ld_ready = (count < DEPTH). It is combinational from count only, so no push is allowed when full even if a pop happens in the same cycle.
- Push: ld_valid && ld_ready at edge N writes {ld_rd, ld_data} to the FIFO tail. The entry is visible at the head from cycle N+1. ld_valid without ld_ready is ignored and the source must hold its values.
- Write-port selection each cycle (result registered at the next edge):
  - alu_valid=1: load {we3=(alu_rd!=0), a3=alu_rd, wd3=alu_data}. No pop.
  - else if FIFO not empty: pop the head; load {we3=(head_rd!=0), a3=head_rd, wd3=head_data}.
  - else: we3=0; a3/wd3 hold their last values.
- Latency:
  - ALU: 1 cycle from alu_valid to we3.
  - Load: minimum 2 cycles from the accepted handshake to we3.
- Writes to r0 are consumed (popped or taken) but always produce we3=0.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - count is updated +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- Busy mask:
  - ld_issue_valid with ld_issue_rd!=0 sets busy[ld_issue_rd] at the edge.
  - A load pop clears busy[head_rd] at the same edge.
  - Set and clear on the same register in the same cycle: set wins (a new load is outstanding).
  - ALU writes never touch busy.
  - busy[0] is always 0.
- Ordering and starvation:
  - The ALU has strict priority and may starve the FIFO. The core must stall the ALU while busy[rd] is set.
  - Load results retire in FIFO order.
  - If an ALU write and a pending load target the same register, the load retires later and wins.

Test Plan:
- Reset release -> we3=0, busy=0, ld_ready=1. Then alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> next cycle we3=1, a3=5, wd3=0xDEADBEEF; the following idle cycle shows we3=0.
- ld_issue rd=7, then 3 cycles later ld_valid rd=7, data=0x1234 -> busy[7]=1 from the edge after issue; we3=1, a3=7, wd3=0x1234 two cycles after the handshake; busy[7]=0 at that same edge.
- DEPTH=2: alu_valid held for 4 cycles while 3 loads are offered -> ld_ready=0 after 2 pushes and the third load stalls. When alu_valid drops, loads retire in order on consecutive cycles and ld_ready returns to 1 after the first pop.
- alu_rd=0 and a load with ld_rd=0 -> both consumed; we3 stays 0; the FIFO count returns to 0; busy is unchanged.
- Same cycle: pop of a load to rd=3 and ld_issue_rd=3 -> busy[3] remains 1. A later load to r3 then clears it.
- Assert rst_n low with 2 FIFO entries and busy=0x0000_0090 -> immediately we3=0, busy=0, ld_ready=1; no writes occur after release.
